// File: rtl/posit_pkg.sv
// rtl/posit_pkg.sv - shared constants, log2 helper and stage records for the posit packer
package posit_pkg;

  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int P_N  = 8;
  localparam int P_ES = 4;
  localparam int P_BS = log2(P_N);
  localparam int RMAX = P_N - 2;
  localparam int RMIN = -(P_N - 2);

  typedef struct packed {
    logic                  sin;
    logic signed [P_BS:0]  k;
    logic [P_ES-1:0]       exp;
    logic [P_N-P_ES-2:0]   frac;
    logic [2:0]            grs;
    logic                  sat_max;
    logic                  sat_min;
    logic                  zero;
    logic                  nar;
  } split_t;

  typedef struct packed {
    logic           sin;
    logic [P_N-2:0] mag;
    logic           rnd;
    logic           sticky;
    logic           sat_max;
    logic           sat_min;
    logic           zero;
    logic           nar;
  } asm_t;

endpackage

// File: rtl/posit_round.sv
// rtl/posit_round.sv - round-to-nearest-even, clamp to 1..maxpos, special values and sign negation
module posit_round #(
  parameter int N = 8
) (
  input  logic         sin,
  input  logic [N-2:0] mag,
  input  logic         rnd,
  input  logic         sticky,
  input  logic         sat_max,
  input  logic         sat_min,
  input  logic         zero,
  input  logic         nar,
  output logic [N-1:0] out
);

  localparam logic [N-2:0] MAG_ONE = {{(N-2){1'b0}}, 1'b1};

  logic [N-1:0] sum;
  logic [N-2:0] m;
  logic [N-1:0] m_ext;

  always_comb begin
    sum = {1'b0, mag} + {{(N-1){1'b0}}, rnd & (sticky | mag[0])};
    // A carry out of N-1 bits would pass maxpos; a zero result would lose a non-zero value.
    if (sum[N-1]) m = '1;
    else if (sum[N-2:0] == '0) m = MAG_ONE;
    else m = sum[N-2:0];
    if (sat_max) m = '1;
    if (sat_min) m = MAG_ONE;
    m_ext = {1'b0, m};
    out = sin ? -m_ext : m_ext;
    if (zero) out = '0;
    if (nar) out = {1'b1, {(N-1){1'b0}}};
  end

endmodule

// File: rtl/data_pack.sv
// rtl/data_pack.sv - three-stage posit encoder: split/clamp, regime assembly, round/negate
module data_pack
  import posit_pkg::*;
#(
  parameter int N  = P_N,
  parameter int es = P_ES,
  parameter int Bs = log2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               Sin,
  input  logic signed [Bs+es:0] eff_e,
  input  logic [N-es+2:0]    mant,
  input  logic               zero_in,
  input  logic               nar_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out
);

  localparam int L = 2 * N + 4;

  split_t       s1_d, s1_q;
  asm_t         s2_d, s2_q;
  logic         s1_valid_d, s1_valid_q;
  logic         s2_valid_d, s2_valid_q;
  logic [N-1:0] out_d, out_q;
  logic         out_valid_d, out_valid_q;
  logic         en;

  logic signed [Bs+es:0] k_full;
  logic [Bs:0]           r;
  logic [L-1:0]          vec;
  logic signed [L-1:0]   shf;
  logic [N-1:0]          rnd_out;
  logic                  unused_hidden;

  assign en            = !out_valid_q || out_ready;
  assign in_ready      = en;
  assign out           = out_q;
  assign out_valid     = out_valid_q;
  assign unused_hidden = mant[N-es+2];

  always_comb begin
    k_full     = eff_e >>> es;
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    if (en) begin
      s1_valid_d   = in_valid;
      s1_d.sin     = Sin;
      s1_d.k       = k_full[Bs:0];
      s1_d.exp     = eff_e[es-1:0];
      s1_d.frac    = mant[N-es+1:3];
      s1_d.grs     = mant[2:0];
      s1_d.sat_max = k_full >= RMAX;
      s1_d.sat_min = k_full < RMIN;
      s1_d.nar     = nar_in;
      s1_d.zero    = zero_in & ~nar_in;
    end
  end

  // Regime pattern "10"/"01" is placed at the top and arithmetic-shifted so the fill repeats its lead bit.
  always_comb begin
    r          = s1_q.k[Bs] ? ~s1_q.k : s1_q.k;
    vec        = {~s1_q.k[Bs], s1_q.k[Bs], s1_q.exp, s1_q.frac, s1_q.grs, {N{1'b0}}};
    shf        = $signed(vec) >>> r;
    s2_d       = s2_q;
    s2_valid_d = s2_valid_q;
    if (en) begin
      s2_valid_d   = s1_valid_q;
      s2_d.sin     = s1_q.sin;
      s2_d.mag     = shf[L-1 -: N-1];
      s2_d.rnd     = shf[L-N];
      s2_d.sticky  = |shf[L-N-1:0];
      s2_d.sat_max = s1_q.sat_max;
      s2_d.sat_min = s1_q.sat_min;
      s2_d.zero    = s1_q.zero;
      s2_d.nar     = s1_q.nar;
    end
  end

  posit_round #(.N(N)) u_round (
    .sin     (s2_q.sin),
    .mag     (s2_q.mag),
    .rnd     (s2_q.rnd),
    .sticky  (s2_q.sticky),
    .sat_max (s2_q.sat_max),
    .sat_min (s2_q.sat_min),
    .zero    (s2_q.zero),
    .nar     (s2_q.nar),
    .out     (rnd_out)
  );

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (en) begin
      out_valid_d = s2_valid_q;
      out_d       = s2_valid_q ? rnd_out : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s1_valid_q  <= 1'b0;
      s2_q        <= '0;
      s2_valid_q  <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s1_valid_q  <= s1_valid_d;
      s2_q        <= s2_d;
      s2_valid_q  <= s2_valid_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_data_pack.sv
// tb/tb_data_pack.sv - self-checking bench for data_pack (N=8, es=4)
module tb_data_pack;

  logic              clk, rst_n, in_valid, in_ready, Sin, zero_in, nar_in;
  logic              out_valid, out_ready;
  logic signed [7:0] eff_e;
  logic [6:0]        mant;
  logic [7:0]        out;

  int checks = 0;
  int errors = 0;

  data_pack dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Sin(Sin), .eff_e(eff_e), .mant(mant), .zero_in(zero_in), .nar_in(nar_in),
    .out_valid(out_valid), .out_ready(out_ready), .out(out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit              s;
    logic signed [7:0] e;
    logic [6:0]      m;
    bit              z;
    bit              nr;
    logic [7:0]      exp;
  } vec_t;

  vec_t       tbl[16];
  logic [7:0] expq[$];
  bit         hold_pending = 0;
  logic [7:0] held_out;
  int         n_pop = 0;

  // Posit encoding from the bit-string definition: regime run, exponent, fraction, then RNE.
  function automatic logic [7:0] ref_enc(bit s, int e, logic [6:0] m, bit z, bit nr);
    int  k, ex, mag, res;
    bit  q[$];
    bit  st;
    if (nr) return 8'h80;
    if (z) return 8'h00;
    k  = (e >= 0) ? e / 16 : -((15 - e) / 16);
    ex = e - 16 * k;
    if (k >= 6) mag = 127;
    else if (k < -6) mag = 1;
    else begin
      if (k >= 0) begin
        for (int i = 0; i <= k; i++) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        for (int i = 0; i < -k; i++) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      for (int i = 3; i >= 0; i--) q.push_back(ex[i]);
      for (int i = 5; i >= 0; i--) q.push_back(m[i]);
      mag = 0;
      for (int i = 0; i < 7; i++) mag = mag * 2 + int'(q[i]);
      st = 0;
      for (int i = 8; i < q.size(); i++) st |= q[i];
      if (q[7] && (st || (mag % 2 == 1))) mag++;
      if (mag > 127) mag = 127;
      if (mag < 1) mag = 1;
    end
    res = s ? (256 - mag) % 256 : mag;
    return res[7:0];
  endfunction

  task automatic drive(input bit iv, input bit s, input logic signed [7:0] e,
                       input logic [6:0] m, input bit z, input bit nr);
    in_valid = iv; Sin = s; eff_e = e; mant = m; zero_in = z; nar_in = nr;
  endtask

  task automatic step(input bit iv, input bit s, input logic signed [7:0] e,
                      input logic [6:0] m, input bit z, input bit nr,
                      input bit ordy, output bit acc);
    @(posedge clk);
    #1;
    drive(iv, s, e, m, z, nr);
    out_ready = ordy;
    @(negedge clk);
    if (hold_pending) begin
      checks++;
      if (!out_valid || out !== held_out) begin
        errors++;
        $display("FAIL stall_stable: got valid=%0b out=%h want valid=1 out=%h", out_valid, out, held_out);
      end
    end
    acc = in_valid && in_ready;
    if (acc) expq.push_back(ref_enc(s, int'(e), m, z, nr));
    if (out_valid && out_ready) begin
      checks++;
      n_pop++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got %h want no output", out);
      end else begin
        logic [7:0] w;
        w = expq.pop_front();
        if (out !== w) begin
          errors++;
          $display("FAIL stream_out: got %h want %h", out, w);
        end
      end
    end
    hold_pending = out_valid && !out_ready;
    held_out     = out;
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 30 && expq.size() > 0; i++) step(0, 0, 8'sd0, 7'h40, 0, 0, 1, acc);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", expq.size());
    end
  endtask

  task automatic rand_vec(output bit s, output logic signed [7:0] e, output logic [6:0] m,
                          output bit z, output bit nr);
    int t;
    s  = 1'($urandom_range(0, 1));
    t  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255)) - 128
                                     : int'($urandom_range(0, 191)) - 96;
    e  = 8'(t);
    m  = {1'b1, 6'($urandom_range(0, 63))};
    z  = ($urandom_range(0, 15) == 0);
    nr = ($urandom_range(0, 15) == 0);
  endtask

  initial begin
    bit              acc, s, z, nr;
    logic signed [7:0] e;
    logic [6:0]      m;
    int              lat, idx, cyc;
    vec_t            seq8[8];

    tbl[0]  = '{0, 8'h00, 7'h40, 0, 0, 8'h40};
    tbl[1]  = '{0, 8'hFF, 7'h40, 0, 0, 8'h3E};
    tbl[2]  = '{1, 8'h00, 7'h40, 0, 0, 8'hC0};
    tbl[3]  = '{0, 8'h00, 7'h60, 0, 0, 8'h41};
    tbl[4]  = '{0, 8'h00, 7'h50, 0, 0, 8'h40};
    tbl[5]  = '{0, 8'h00, 7'h58, 0, 0, 8'h41};
    tbl[6]  = '{0, 8'h7F, 7'h40, 0, 0, 8'h7F};
    tbl[7]  = '{0, 8'h80, 7'h40, 0, 0, 8'h01};
    tbl[8]  = '{0, 8'h00, 7'h40, 1, 0, 8'h00};
    tbl[9]  = '{1, 8'h00, 7'h40, 1, 1, 8'h80};
    tbl[10] = '{1, 8'h7F, 7'h40, 0, 0, 8'h81};
    tbl[11] = '{0, 8'h0F, 7'h7F, 0, 0, 8'h60};
    tbl[12] = '{0, 8'h5F, 7'h40, 0, 0, 8'h7F};
    tbl[13] = '{0, 8'hA8, 7'h40, 0, 0, 8'h02};
    tbl[14] = '{0, 8'hA0, 7'h40, 0, 0, 8'h01};
    tbl[15] = '{1, 8'h00, 7'h60, 0, 0, 8'hBF};

    rst_n = 1'b0;
    out_ready = 1'b1;
    drive(0, 0, 8'sd0, 7'h40, 0, 0);
    #3;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    if (out !== 8'h00) begin errors++; $display("FAIL reset_out: got %h want 00", out); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      drive(1, tbl[i].s, tbl[i].e, tbl[i].m, tbl[i].z, tbl[i].nr);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 8) begin
        @(posedge clk);
        #1;
        lat++;
      end
      checks += 2;
      if (lat != 2) begin errors++; $display("FAIL latency[%0d]: got %0d want 2", i, lat); end
      if (out !== tbl[i].exp) begin errors++; $display("FAIL vec[%0d]: got %h want %h", i, out, tbl[i].exp); end
    end

    foreach (seq8[i]) begin
      rand_vec(s, e, m, z, nr);
      seq8[i] = '{s, e, m, z, nr, 8'h00};
    end
    n_pop = 0;
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 100) begin
      step(1, seq8[idx].s, seq8[idx].e, seq8[idx].m, seq8[idx].z, seq8[idx].nr,
           (cyc % 4 == 0) || (cyc % 4 == 3), acc);
      if (acc) idx++;
      cyc++;
    end
    drain();
    checks++;
    if (n_pop != 8) begin errors++; $display("FAIL burst_count: got %0d want 8", n_pop); end

    for (int i = 0; i < 400; i++) begin
      rand_vec(s, e, m, z, nr);
      step(1'($urandom_range(0, 3) != 0), s, e, m, z, nr, 1'($urandom_range(0, 2) != 0), acc);
    end
    drain();

    for (int i = 0; i < 3; i++) begin
      rand_vec(s, e, m, z, nr);
      step(1, s, e, m, z, nr, 1, acc);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b want 0", out_valid); end
    if (out !== 8'h00) begin errors++; $display("FAIL async_out: got %h want 00", out); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL async_ready: got %b want 1", in_ready); end
    expq.delete();
    hold_pending = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL stale_out: got valid=%b out=%h want valid=0", out_valid, out); end
    end
    step(1, 1'b0, 8'hFF, 7'h40, 0, 0, 1, acc);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_pack.md
DATA_PACK -- requirements
Module: data_pack

Interface
REQ-001 Parameter N, default 8: posit width in bits.
REQ-002 Parameter es, default 4: exponent field width.
REQ-003 Parameter Bs, default log2(N): regime magnitude width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 in_valid  input  1  upstream fields valid this cycle.
REQ-007 in_ready  output  1  block accepts fields this cycle.
REQ-008 Sin  input  1  sign of value.
REQ-009 eff_e  input  Bs+es+1, signed  effective exponent {regime, exp}.
REQ-010 mant  input  N-es+3  {hidden 1, fraction, 3 guard/round/sticky bits}.
REQ-011 zero_in  input  1  value is exact zero; overrides all fields.
REQ-012 nar_in  input  1  value is NaR; overrides zero_in and all fields.
REQ-013 out_valid  output  1  out holds an encoded posit.
REQ-014 out_ready  input  1  downstream accepts out this cycle.
REQ-015 out  output  N  encoded posit, two's complement for negative values.

Function
REQ-016 Transfer in at rising edge when in_valid && in_ready; out transfers when out_valid && out_ready.
REQ-017 Three-stage pipeline: S1 split/clamp, S2 assemble/shift, S3 round/negate; latency 3 cycles with out_ready held high; throughput 1 per cycle.
REQ-018 Global advance enable = !out_valid || out_ready; all stages hold when disabled; in_ready equals the enable.
REQ-019 While stalled, out and out_valid remain stable until accepted.
REQ-020 S1: k = eff_e >>> es (arithmetic); exp = eff_e[es-1:0].
REQ-021 S1: k >= N-2 flags saturate-max; k < -(N-2) flags saturate-min.
REQ-022 S2: regime field is k+1 ones then a zero for k >= 0, and -k zeros then a one for k < 0.
REQ-023 S2: concatenate {regime, exp, mant fraction, guard bits}, left-justify into N-1 bits, and retain the bits shifted out as round/sticky.
REQ-024 S3: round to nearest, ties to even, on the N-1 bit magnitude; a carry into regime is legal and yields the next larger posit.
REQ-025 S3: rounding never yields 0 from a non-zero input or exceeds maxpos; magnitude clamps to 1..2^(N-1)-1.
REQ-026 Saturate-max yields magnitude 0x7F (N=8); saturate-min yields magnitude 0x01.
REQ-027 Sin=1 yields out = two's complement of {0, magnitude}.
REQ-028 zero_in yields out = 0; nar_in yields out = 1 followed by N-1 zeros, regardless of Sin.
REQ-029 Bubbles (in_valid=0) propagate as invalid stages; they are not collapsed.

Reset
REQ-030 rst_n low clears all stage valid bits, out_valid=0 and out=0 immediately (asynchronous).
REQ-031 in_ready=1 during and after reset; in-flight data is discarded without an output.
REQ-032 Reset deassertion is synchronised externally; the first transfer is possible on the first edge with rst_n high.

Structure
REQ-033 Shared package posit_pkg holds the log2 function, the Rmax/Rmin constants, and a packed struct for the stage-to-stage fields (sign, k, exp, frac, flags).
REQ-034 One sub-module posit_round performs S3 rounding, clamping and sign negation combinationally; registers stay in data_pack.

Verification (N=8, es=4)
REQ-035 Sin=0, eff_e=0, mant=7'b1000000 -> out=0x40 three cycles later.
REQ-036 Sin=0, eff_e=-1, mant=7'b1000000 -> 0x3E; same with Sin=1, eff_e=0 -> 0xC0.
REQ-037 Rounding at eff_e=0: mant=7'b1100000 -> 0x41; 7'b1010000 (tie) -> 0x40; 7'b1011000 -> 0x41.
REQ-038 eff_e=+127 -> 0x7F; eff_e=-128 -> 0x01; zero_in -> 0x00; nar_in with Sin=1 -> 0x80.
REQ-039 Back-to-back stream of 8 inputs with out_ready toggling 1,0,0,1 -> all 8 outputs in order, none lost or duplicated, out stable while stalled.
REQ-040 rst_n pulsed low with 3 items in flight -> out_valid=0 at once, no stale output after release, next input encoded correctly.
